// File: rtl/regx_psif_pkg.sv
// Shared definitions for PS register interfaces:
// region codes, default filler word, event register offsets.
package regx_psif_pkg;

  localparam logic [31:0] NO_REG_CODE_DEF = 32'hcafecafe;

  typedef enum logic [2:0] {
    RG_NONE,
    RG_CTRL,
    RG_STAT,
    RG_STKY,
    RG_MASK
  } region_t;

  function automatic int evt_sticky_off(int nc, int ns);
    return nc + ns;
  endfunction

  function automatic int evt_mask_off(int nc, int ns);
    return nc + ns + 1;
  endfunction

endpackage

// File: rtl/regx_psif_addr_dec.sv
// PS window decoder: hit test, word index and register region.
// Purely combinational so other PS interfaces can reuse it.
module psif_addr_dec
  import regx_psif_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int ADDR_RANGE_WIDTH = 4,
  parameter int NUM_CTRL = 2,
  parameter int NUM_STAT = 2
) (
  input  logic [ADDR_WIDTH-1:0]       addr,
  output logic                        hit,
  output logic [ADDR_RANGE_WIDTH-1:0] idx,
  output logic [2:0]                  region
);

  localparam int ARW = ADDR_RANGE_WIDTH;
  localparam int AW = ADDR_WIDTH;

  localparam logic [ARW-1:0] STAT_LO =
    ARW'(NUM_CTRL);
  localparam logic [ARW-1:0] STKY_IDX =
    ARW'(evt_sticky_off(NUM_CTRL, NUM_STAT));
  localparam logic [ARW-1:0] MASK_IDX =
    ARW'(evt_mask_off(NUM_CTRL, NUM_STAT));

  if (NUM_CTRL + NUM_STAT + 2 > 2**ARW) begin : g_bad_map
    $error("register map does not fit window");
  end

  assign hit = addr[AW-1:ARW] == BASE_ADDR[AW-1:ARW];
  assign idx = addr[ARW-1:0] - BASE_ADDR[ARW-1:0];

  always_comb begin
    region = RG_NONE;
    if (hit) begin
      if (idx < STAT_LO)
        region = RG_CTRL;
      else if (idx < STKY_IDX)
        region = RG_STAT;
      else if (idx == STKY_IDX)
        region = RG_STKY;
      else if (idx == MASK_IDX)
        region = RG_MASK;
    end
  end

endmodule

// File: rtl/regx_psif.sv
// PS register bank: RW control, RO status, sticky W1C events
// with maskable registered interrupt, 1-cycle registered reads.
module regx_psif
  import regx_psif_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int ADDR_RANGE_WIDTH = 4,
  parameter int NUM_CTRL = 2,
  parameter int NUM_STAT = 2,
  parameter int NUM_EVT = 8,
  parameter logic [NUM_CTRL*DATA_WIDTH-1:0]
    CTRL_RST_VAL = '0,
  parameter logic [DATA_WIDTH-1:0]
    NO_REG_CODE = DATA_WIDTH'(NO_REG_CODE_DEF)
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_odat,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_idat,
  input  logic [NUM_EVT-1:0]             evt_in,
  output logic                           irq,
  input  logic [ADDR_WIDTH-1:0]          ps_addr,
  input  logic                           ps_wren,
  input  logic [DATA_WIDTH-1:0]          ps_wdat,
  output logic                           ps_wack,
  input  logic                           ps_rden,
  output logic [DATA_WIDTH-1:0]          ps_rdat,
  output logic                           ps_rvld
);

  localparam int DW = DATA_WIDTH;
  localparam int NC = NUM_CTRL;
  localparam int NS = NUM_STAT;
  localparam int NE = NUM_EVT;
  localparam int ARW = ADDR_RANGE_WIDTH;

  if (NE < 1 || NE > DW) begin : g_bad_evt
    $error("NUM_EVT out of range");
  end

  logic           hit;
  logic [ARW-1:0] idx;
  logic [2:0]     region;

  psif_addr_dec #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .BASE_ADDR        (BASE_ADDR),
    .ADDR_RANGE_WIDTH (ADDR_RANGE_WIDTH),
    .NUM_CTRL         (NUM_CTRL),
    .NUM_STAT         (NUM_STAT)
  ) u_dec (
    .addr   (ps_addr),
    .hit    (hit),
    .idx    (idx),
    .region (region)
  );

  logic [DW-1:0] ctrl_q [NC];
  logic [NE-1:0] stky_q;
  logic [NE-1:0] mask_q;
  logic [NE-1:0] stky_d;
  logic [NE-1:0] mask_d;
  logic [NE-1:0] clr;

  logic wr, rd;
  logic is_ctrl, is_stat, is_stky, is_mask;
  logic [DW-1:0] ctrl_sel, stat_sel, rd_val;

  assign wr = ps_wren & hit;
  assign rd = ps_rden & hit;

  assign is_ctrl = region == RG_CTRL;
  assign is_stat = region == RG_STAT;
  assign is_stky = region == RG_STKY;
  assign is_mask = region == RG_MASK;

  for (genvar g = 0; g < NC; g++) begin : g_ctrl
    assign ctrl_odat[g*DW +: DW] = ctrl_q[g];
  end

  always_comb begin
    ctrl_sel = '0;
    for (int i = 0; i < NC; i++)
      if (idx == ARW'(i))
        ctrl_sel = ctrl_q[i];
  end

  always_comb begin
    stat_sel = '0;
    for (int j = 0; j < NS; j++)
      if (idx == ARW'(NC + j))
        stat_sel = stat_idat[j*DW +: DW];
  end

  always_comb begin
    rd_val = NO_REG_CODE;
    unique case (1'b1)
      is_ctrl: rd_val = ctrl_sel;
      is_stat: rd_val = stat_sel;
      is_stky: rd_val = DW'(stky_q);
      is_mask: rd_val = DW'(mask_q);
      default: ;
    endcase
  end

  // New events win over a same-cycle W1C of the same bit.
  always_comb begin
    clr = '0;
    if (wr && is_stky)
      clr = ps_wdat[NE-1:0];
    stky_d = (stky_q & ~clr) | evt_in;
    mask_d = mask_q;
    if (wr && is_mask)
      mask_d = ps_wdat[NE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NC; i++)
        ctrl_q[i] <= CTRL_RST_VAL[i*DW +: DW];
      stky_q  <= '0;
      mask_q  <= '0;
      irq     <= 1'b0;
      ps_wack <= 1'b0;
      ps_rvld <= 1'b0;
      ps_rdat <= '0;
    end else begin
      for (int i = 0; i < NC; i++)
        if (wr && is_ctrl && idx == ARW'(i))
          ctrl_q[i] <= ps_wdat;
      stky_q  <= stky_d;
      mask_q  <= mask_d;
      irq     <= |(stky_d & mask_d);
      ps_wack <= wr;
      ps_rvld <= rd;
      ps_rdat <= rd ? rd_val : '0;
    end
  end

endmodule
